// File: rtl/qpmm_iter_if.sv
// qpmm_iter_if: operand/result valid-ready bundle for the iterative QPMM core.
// master drives operands and result backpressure; slave is the core.
interface qpmm_iter_if #(
    parameter int K = 17,
    parameter int N = 16
);
    localparam int SW = K * (N + 1) + 2;
    logic            in_valid;
    logic            in_ready;
    logic [N*K-1:0]  in_a;
    logic [N*K-1:0]  in_b;
    logic [N*K-1:0]  in_mpp;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_z;
    modport master (
        output in_valid, in_a, in_b, in_mpp, out_ready,
        input  in_ready, out_valid, out_z
    );
    modport slave (
        input  in_valid, in_a, in_b, in_mpp, out_ready,
        output in_ready, out_valid, out_z
    );
endinterface

// File: rtl/qpmm_iter.sv
// qpmm_iter: runtime-modulus quotient-pipelined Montgomery multiplier that
// runs the N+D+1 QPMM rows serially through one K x (N*K) MAC row.
module qpmm_iter #(
    parameter int K = 17,
    parameter int N = 16,
    parameter int D = 1
) (
    input logic        clk,
    input logic        rstn,
    qpmm_iter_if.slave io
);
    localparam int SW = K * (N + 1) + 2;
    localparam int NK = N * K;
    localparam int DQ = (D > 0) ? D : 1;
    localparam int CW = $clog2(N + D + 2);
    localparam logic [CW-1:0] LAST = CW'(N + D);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [NK-1:0]  a_q, a_d, b_q, b_d, mpp_q, mpp_d;
    logic [SW-1:0]  s_q, s_d, s_nx, z_q, z_d;
    logic [K-1:0]   ql_q [DQ];
    logic [K-1:0]   ql_d [DQ];
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ov_q, ov_d, acc;
    logic [K-1:0]   q_cur, q_use;

    // With D = 0 the quotient of this row feeds straight back; otherwise the
    // oldest entry of the shift line is q_{i-D}.
    assign q_cur = s_q[K-1:0];
    assign q_use = (D == 0) ? q_cur : ql_q[DQ-1];
    assign s_nx  = (s_q >> K)
                 + {{(SW-K){1'b0}}, q_use} * {{(SW-NK){1'b0}}, mpp_q}
                 + {{(SW-K){1'b0}}, b_q[K-1:0]} * {{(SW-NK){1'b0}}, a_q};

    assign io.in_ready  = (state_q == IDLE) || (state_q == DONE && io.out_ready);
    assign acc          = io.in_valid && io.in_ready;
    assign io.out_valid = ov_q;
    assign io.out_z     = z_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mpp_d   = mpp_q;
        s_d     = s_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        ql_d    = ql_q;
        if (acc) begin
            state_d = RUN;
            a_d     = io.in_a;
            b_d     = io.in_b;
            mpp_d   = io.in_mpp;
            s_d     = '0;
            cnt_d   = '0;
            ov_d    = 1'b0;
            for (int i = 0; i < DQ; i++) ql_d[i] = '0;
        end else if (state_q == DONE && io.out_ready) begin
            state_d = IDLE;
            ov_d    = 1'b0;
        end else if (state_q == RUN) begin
            s_d     = s_nx;
            b_d     = b_q >> K;
            cnt_d   = cnt_q + 1'b1;
            ql_d[0] = q_cur;
            for (int i = 1; i < DQ; i++) ql_d[i] = ql_q[i-1];
            if (cnt_q == LAST) begin
                state_d = DONE;
                z_d     = s_nx;
                ov_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mpp_q   <= '0;
            s_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            for (int i = 0; i < DQ; i++) ql_q[i] <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mpp_q   <= mpp_d;
            s_q     <= s_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            ql_q    <= ql_d;
        end
    end
endmodule

// File: tb/tb_qpmm_iter.sv
// tb_qpmm_iter: checks qpmm_iter against the integer QPMM recurrence, using a
// small D=0 instance for hand-derived vectors and a default instance with a scoreboard.
module tb_qpmm_iter;
    localparam int K  = 17;
    localparam int N  = 16;
    localparam int D  = 1;
    localparam int SW = K * (N + 1) + 2;
    localparam int NK = N * K;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    qpmm_iter_if #(.K(K), .N(N)) bif ();
    qpmm_iter_if #(.K(4), .N(2)) sif ();

    qpmm_iter #(.K(K), .N(N), .D(D)) dut   (.clk(clk), .rstn(rstn), .io(bif));
    qpmm_iter #(.K(4), .N(2), .D(0)) dut_s (.clk(clk), .rstn(rstn), .io(sif));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rises = 0;
    int rise_cyc = 0;
    int prev_rise = 0;
    logic ov_prev = 1'b0;

    logic rnd_rdy = 1'b0;
    logic rr = 1'b0;
    logic rdy = 1'b0;
    assign bif.out_ready = rnd_rdy ? rr : rdy;
    always @(posedge clk) begin
        #1 rr = 1'($urandom_range(0, 1));
    end
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [SW-1:0] z;
        int            t;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [13:0] z;
    } vec_t;
    vec_t tv[6];

    task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [SW-1:0] model(input logic [NK-1:0] a, input logic [NK-1:0] b,
                                            input logic [NK-1:0] m);
        logic [SW-1:0] s, qd, bi;
        logic [K-1:0]  qs [N+D+1];
        s = '0;
        for (int i = 0; i <= N + D; i++) begin
            qs[i] = s[K-1:0];
            qd = (i >= D) ? SW'(qs[i-D]) : '0;
            bi = (i < N) ? SW'(b[K*i +: K]) : '0;
            s = (s >> K) + qd * SW'(m) + bi * SW'(a);
        end
        return s;
    endfunction

    function automatic logic [NK-1:0] rnd();
        logic [NK-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r = {r[NK-33:0], 32'($urandom)};
        return r;
    endfunction

    // Scoreboard: expectations pushed on accept, popped on the result handshake.
    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
            ov_prev = 1'b0;
        end else begin
            if (bif.out_valid && !ov_prev) begin
                prev_rise = rise_cyc;
                rise_cyc = cyc;
                rises++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: out_valid rose with no pending operation");
                end else chk("latency", SW'(cyc - sb[0].t), SW'(N + D + 1));
            end
            if (bif.out_valid && bif.out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("z", bif.out_z, e.z);
            end
            if (bif.in_valid && bif.in_ready)
                sb.push_back('{model(bif.in_a, bif.in_b, bif.in_mpp), cyc + 1});
            ov_prev = bif.out_valid;
        end
    end

    task automatic send(input logic [NK-1:0] a, input logic [NK-1:0] b, input logic [NK-1:0] m);
        int n;
        n = 0;
        bif.in_valid = 1'b1;
        bif.in_a = a;
        bif.in_b = b;
        bif.in_mpp = m;
        @(negedge clk);
        while (!bif.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bif.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0");
        end
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
    endtask

    task automatic wait_ov(input int lim);
        int n;
        n = 0;
        while (!bif.out_valid && n < lim) begin
            @(posedge clk);
            #1 n++;
        end
        if (!bif.out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: out_valid never rose");
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [255:0]   p_bn;
    logic [63:0]    inv;
    logic [33:0]    mlow;
    logic [289:0]   mt;
    logic [NK-1:0]  bn_mpp, ta, tb, tm;
    logic [SW-1:0]  expz;
    int lat, n, r0;

    initial begin
        p_bn = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
        inv = p_bn[63:0];
        repeat (6) inv = inv * (64'd2 - p_bn[63:0] * inv);
        mlow = 34'(64'd0 - inv);
        mt = 290'(mlow) * 290'(p_bn);
        bn_mpp = NK'((mt + 290'd1) >> 34);

        tv[0] = '{8'd3,   8'd5,   14'd71};
        tv[1] = '{8'd0,   8'd0,   14'd0};
        tv[2] = '{8'd1,   8'd1,   14'd81};
        tv[3] = '{8'd255, 8'd255, 14'd335};
        tv[4] = '{8'd16,  8'd1,   14'd9};
        tv[5] = '{8'd200, 8'd17,  14'd125};

        bif.in_valid = 1'b0; bif.in_a = '0; bif.in_b = '0; bif.in_mpp = '0;
        sif.in_valid = 1'b0; sif.in_a = '0; sif.in_b = '0; sif.in_mpp = '0;
        sif.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", SW'(bif.in_ready), SW'(1));
        chk("rst_out_valid", SW'(bif.out_valid), '0);
        chk("rst_out_z", bif.out_z, '0);
        chk("rst_s_out_valid", SW'(sif.out_valid), '0);
        rstn = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_in_ready", SW'(bif.in_ready), SW'(1));

        // Small D=0 instance: hand-derived vectors (K=4, N=2, P=13, Mpp=9).
        for (int i = 0; i < 6; i++) begin
            sif.in_a = tv[i].a;
            sif.in_b = tv[i].b;
            sif.in_mpp = 8'd9;
            sif.in_valid = 1'b1;
            chk("s_in_ready", SW'(sif.in_ready), SW'(1));
            @(posedge clk);
            #1 sif.in_valid = 1'b0;
            lat = 0;
            while (!sif.out_valid && lat < 10) begin
                @(posedge clk);
                #1 lat++;
            end
            chk("s_latency", SW'(lat), SW'(3));
            chk("s_z", SW'(sif.out_z), SW'(tv[i].z));
            chk("s_modp", SW'(sif.out_z % 14'd13),
                SW'((32'(tv[i].a) * 32'(tv[i].b) * 3) % 13));
            sif.out_ready = 1'b1;
            @(posedge clk);
            #1 sif.out_ready = 1'b0;
            chk("s_ov_clear", SW'(sif.out_valid), '0);
        end

        // A = 0 gives a zero product regardless of B and Mpp.
        rdy = 1'b0;
        send('0, rnd(), rnd());
        wait_ov(40);
        chk("a0_z", bif.out_z, '0);
        rdy = 1'b1;
        @(posedge clk);
        #1 rdy = 1'b0;

        // Result held under backpressure; new operands must not be taken.
        ta = rnd(); tb = rnd(); tm = bn_mpp;
        expz = model(ta, tb, tm);
        send(ta, tb, tm);
        wait_ov(40);
        for (int i = 0; i < 10; i++) begin
            bif.in_valid = 1'(i % 2 == 0);
            bif.in_a = rnd();
            bif.in_b = rnd();
            @(negedge clk);
            chk("bp_z", bif.out_z, expz);
            chk("bp_in_ready", SW'(bif.in_ready), '0);
            chk("bp_out_valid", SW'(bif.out_valid), SW'(1));
            @(posedge clk);
            #1;
        end
        bif.in_valid = 1'b0;
        rdy = 1'b1;
        @(posedge clk);
        #1 rdy = 1'b0;
        chk("bp_released_ov", SW'(bif.out_valid), '0);
        chk("bp_idle_in_ready", SW'(bif.in_ready), SW'(1));

        // Back-to-back: second accept lands on the first result's handshake edge.
        rdy = 1'b1;
        r0 = rises;
        send(rnd(), rnd(), bn_mpp);
        send(rnd(), rnd(), bn_mpp);
        n = 0;
        while (rises < r0 + 2 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("b2b_rises", SW'(rises - r0), SW'(2));
        chk("b2b_spacing", SW'(rise_cyc - prev_rise), SW'(N + D + 2));
        @(posedge clk);
        #1 rdy = 1'b0;

        // Asynchronous reset mid-RUN aborts with no output.
        send(rnd(), rnd(), bn_mpp);
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("abort_out_valid", SW'(bif.out_valid), '0);
        chk("abort_out_z", bif.out_z, '0);
        chk("abort_in_ready", SW'(bif.in_ready), SW'(1));
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (25) @(posedge clk);
        #1 chk("abort_no_output", SW'(bif.out_valid), '0);

        // Random operands with BN254 Mpp and random result backpressure.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) send(rnd(), rnd(), bn_mpp);
        n = 0;
        while (sb.size() > 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #2 rnd_rdy = 1'b0;
        chk("sb_drained", SW'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qpmm_iter.md
# qpmm_iter

Iterative, runtime-modulus successor to the fully unrolled QPMM datapath. It computes a radix-2^K quotient-pipelined Montgomery product by running the N+D+1 QPMM rows serially through one row of K×(N·K) multiply-accumulate logic. The modulus constant Mpp arrives with each operation, so one instance serves several curves. It sits behind a valid/ready front end with result backpressure, and trades throughput for area in multi-curve or low-rate pairing datapaths.

## Interface
Parameters:
- K, 17: digit width in bits (DSP operand width).
- N, 16: number of K-bit digits in A, B and Mpp.
- D, 1: quotient pipelining delay, in iterations (0 allowed).
- SW (localparam), K*(N+1)+2: accumulator and result width.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: asynchronous active-low reset.
- in_valid, in, 1: operand set valid.
- in_ready, out, 1: block can accept an operand set.
- in_a, in, N*K: multiplicand A.
- in_b, in, N*K: multiplier B; digit b_i = in_b[K*i +: K].
- in_mpp, in, N*K: Mpp = (M~+1)/2^(K(D+1)), where M~ = (−P^-1 mod 2^(K(D+1)))·P.
- out_valid, out, 1: out_z valid.
- out_ready, in, 1: consumer accepts out_z.
- out_z, out, SW: result S_{N+D+1}.

## Operation
- Recurrence, for i = 0..N+D (N+D+1 iterations), with S_0 = 0:
  - q_i = S_i mod 2^K.
  - S_{i+1} = floor(S_i/2^K) + q_{i−D}·Mpp + b_i·A.
  - q_j = 0 for j < 0; b_i = 0 for i ≥ N.
- All arithmetic is unsigned and modulo 2^SW. With A, B, Mpp < 2^(NK), the sum fits in SW bits and no wrap occurs.
- Quotient history: a D-entry K-bit shift line, zeroed at accept. When D = 0, q_i is used directly.
- B is held in a shift register that moves right by K bits per iteration and zero-fills.
- For D = 0, out_z ≡ A·B·2^(−KN) mod P.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready = 1. On in_valid: latch A, B and Mpp, clear S, the q line and the counter, then go to RUN.
  - RUN: one iteration per cycle and the counter increments. The iteration with counter = N+D writes out_z from S_{N+D+1} and the state goes to DONE.
  - DONE: out_valid = 1 and out_z is held stable. When out_ready = 1 the state goes to IDLE, or back to RUN if a new operand set is accepted on the same edge.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from the registered state and out_ready.
- in_valid is ignored while in_ready = 0. Operands are sampled only at the accept edge, so later input changes have no effect.

## Timing
- Reset values: state IDLE, out_valid 0, out_z 0, S 0, q line 0, counter 0. in_ready reads 1 while rstn is low and after release.
- Latency: accept at edge e0; out_valid rises at edge e0+N+D+1 (default parameters: 18 cycles).
- Minimum initiation interval is N+D+2 cycles, reached when out_ready is held at 1.
- out_valid stays at 1 and out_z stays constant until the out_ready handshake edge. On that edge out_valid clears, unless it is refilled by a new accept.
- Reset asserted during RUN or DONE aborts the operation with no output. All state returns to reset values on assertion, without waiting for a clock edge.
- out_ready while out_valid = 0 has no effect.

## Test plan
- Reset asserted mid-RUN at cycle 5 -> out_valid=0 and out_z=0 immediately; in_ready=1 after release; a later operation completes correctly.
- K=4, N=2, D=0, P=13, Mpp=9, A=3, B=5 -> out_valid exactly 3 cycles after accept, out_z=71 (71 mod 13 = 6 = 15·2^−8 mod 13).
- Defaults, A=0, B=arbitrary, Mpp=arbitrary -> out_z=0, out_valid at e0+18.
- out_ready held 0 for 10 cycles after out_valid, in_valid toggling with new operands -> out_z constant, in_ready=0, no accept; release gives one handshake, then IDLE.
- Back-to-back: in_valid and out_ready held 1 with two operand sets -> second accept on the first result's handshake edge, results spaced N+D+2=19 cycles apart, both bit-exact.
- 1000 random operand sets with default BN254 Mpp and random out_ready -> bit-exact match to the integer recurrence. For D=0, also check out_z ≡ A·B·2^(−KN) mod P.
